// File: rtl/mem_arbiter.sv
// Single-port arbiter sharing a variable-latency unified memory between fetch and data.
// Data has priority; a saturating counter forces a fetch grant after STARVE_LIMIT data wins.
module mem_arbiter #(
  parameter int unsigned ADDR_WIDTH   = 32,
  parameter int unsigned DATA_WIDTH   = 32,
  parameter int unsigned STARVE_LIMIT = 4
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  flush_i,
  input  logic                  if_req_valid_i,
  input  logic [ADDR_WIDTH-1:0] if_req_addr_i,
  output logic                  if_req_ready_o,
  output logic                  if_rsp_valid_o,
  output logic [DATA_WIDTH-1:0] if_rsp_data_o,
  input  logic                  d_req_valid_i,
  input  logic                  d_req_we_i,
  input  logic [ADDR_WIDTH-1:0] d_req_addr_i,
  input  logic [DATA_WIDTH-1:0] d_req_wdata_i,
  output logic                  d_req_ready_o,
  output logic                  d_rsp_valid_o,
  output logic [DATA_WIDTH-1:0] d_rsp_data_o,
  output logic                  mem_req_valid_o,
  output logic                  mem_req_we_o,
  output logic [ADDR_WIDTH-1:0] mem_req_addr_o,
  output logic [DATA_WIDTH-1:0] mem_req_wdata_o,
  input  logic                  mem_rsp_valid_i,
  input  logic [DATA_WIDTH-1:0] mem_rsp_data_i,
  output logic                  busy_o
);

  localparam int unsigned     CNT_W   = $clog2(STARVE_LIMIT + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STARVE_LIMIT);
  localparam logic            OWN_I   = 1'b0;
  localparam logic            OWN_D   = 1'b1;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_WAIT  = 2'd2,
    S_RESP  = 2'd3
  } state_e;

  state_e                state_q, state_d;
  logic                  owner_q, owner_d;
  logic                  we_q, we_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
  logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
  logic                  drop_q, drop_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic                  live_q;
  logic                  win_i_c, win_d_c;
  logic                  out_en_c, issue_c;

  // State register
  always_ff @(posedge clk_i) begin
    if (!rst_i) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  // Transaction registers; live_q holds outputs quiet for the first cycle after reset
  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      owner_q <= 1'b0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      drop_q  <= 1'b0;
      cnt_q   <= '0;
      live_q  <= 1'b0;
    end else begin
      owner_q <= owner_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      drop_q  <= drop_d;
      cnt_q   <= cnt_d;
      live_q  <= 1'b1;
    end
  end

  // Arbitration and next-state logic
  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    we_d    = we_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    drop_d  = drop_q;
    cnt_d   = cnt_q;
    win_i_c = 1'b0;
    win_d_c = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (live_q) begin
          if (d_req_valid_i && !(if_req_valid_i && (cnt_q == CNT_MAX))) win_d_c = 1'b1;
          else if (if_req_valid_i)                                      win_i_c = 1'b1;
        end
        if (win_d_c) begin
          state_d = S_ISSUE;
          owner_d = OWN_D;
          we_d    = d_req_we_i;
          addr_d  = d_req_addr_i;
          wdata_d = d_req_wdata_i;
          if (if_req_valid_i && (cnt_q != CNT_MAX)) cnt_d = cnt_q + CNT_W'(1);
        end else if (win_i_c) begin
          state_d = S_ISSUE;
          owner_d = OWN_I;
          we_d    = 1'b0;
          addr_d  = if_req_addr_i;
          wdata_d = '0;
          cnt_d   = '0;
        end
      end
      S_ISSUE: begin
        state_d = S_WAIT;
        if (flush_i && (owner_q == OWN_I)) drop_d = 1'b1;
      end
      S_WAIT: begin
        if (flush_i && (owner_q == OWN_I)) drop_d = 1'b1;
        if (mem_rsp_valid_i) begin
          state_d = S_RESP;
          rdata_d = mem_rsp_data_i;
        end
      end
      S_RESP: begin
        state_d = S_IDLE;
        drop_d  = 1'b0;
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign out_en_c = rst_i & live_q;
  assign issue_c  = out_en_c & (state_q == S_ISSUE);

  assign if_req_ready_o  = out_en_c & win_i_c;
  assign d_req_ready_o   = out_en_c & win_d_c;
  // A flush in the response cycle itself still kills the fetch pulse
  assign if_rsp_valid_o  = out_en_c & (state_q == S_RESP) & (owner_q == OWN_I) & ~drop_q & ~flush_i;
  assign d_rsp_valid_o   = out_en_c & (state_q == S_RESP) & (owner_q == OWN_D);
  assign if_rsp_data_o   = out_en_c ? rdata_q : '0;
  assign d_rsp_data_o    = out_en_c ? rdata_q : '0;
  assign mem_req_valid_o = issue_c;
  assign mem_req_we_o    = issue_c & we_q;
  assign mem_req_addr_o  = issue_c ? addr_q : '0;
  assign mem_req_wdata_o = issue_c ? wdata_q : '0;
  assign busy_o          = out_en_c & (state_q != S_IDLE);

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: transaction table, arbitration table, hand sequences, response scoreboard.
module tb_mem_arbiter;

  localparam int unsigned AW = 32;
  localparam int unsigned DW = 32;

  logic          clk_i = 1'b0;
  logic          rst_i = 1'b0;
  logic          flush_i = 1'b0;
  logic          if_req_valid_i = 1'b0;
  logic [AW-1:0] if_req_addr_i = '0;
  logic          if_req_ready_o;
  logic          if_rsp_valid_o;
  logic [DW-1:0] if_rsp_data_o;
  logic          d_req_valid_i = 1'b0;
  logic          d_req_we_i = 1'b0;
  logic [AW-1:0] d_req_addr_i = '0;
  logic [DW-1:0] d_req_wdata_i = '0;
  logic          d_req_ready_o;
  logic          d_rsp_valid_o;
  logic [DW-1:0] d_rsp_data_o;
  logic          mem_req_valid_o;
  logic          mem_req_we_o;
  logic [AW-1:0] mem_req_addr_o;
  logic [DW-1:0] mem_req_wdata_o;
  logic          mem_rsp_valid_i = 1'b0;
  logic [DW-1:0] mem_rsp_data_i = '0;
  logic          busy_o;

  mem_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .STARVE_LIMIT(4)) dut (
    .clk_i(clk_i), .rst_i(rst_i), .flush_i(flush_i),
    .if_req_valid_i(if_req_valid_i), .if_req_addr_i(if_req_addr_i), .if_req_ready_o(if_req_ready_o),
    .if_rsp_valid_o(if_rsp_valid_o), .if_rsp_data_o(if_rsp_data_o),
    .d_req_valid_i(d_req_valid_i), .d_req_we_i(d_req_we_i), .d_req_addr_i(d_req_addr_i),
    .d_req_wdata_i(d_req_wdata_i), .d_req_ready_o(d_req_ready_o),
    .d_rsp_valid_o(d_rsp_valid_o), .d_rsp_data_o(d_rsp_data_o),
    .mem_req_valid_o(mem_req_valid_o), .mem_req_we_o(mem_req_we_o), .mem_req_addr_o(mem_req_addr_o),
    .mem_req_wdata_o(mem_req_wdata_o), .mem_rsp_valid_i(mem_rsp_valid_i), .mem_rsp_data_i(mem_rsp_data_i),
    .busy_o(busy_o)
  );

  always #5 clk_i = ~clk_i;

  logic [134:0] all_outs;
  assign all_outs = {if_req_ready_o, if_rsp_valid_o, if_rsp_data_o, d_req_ready_o, d_rsp_valid_o,
                     d_rsp_data_o, mem_req_valid_o, mem_req_we_o, mem_req_addr_o, mem_req_wdata_o, busy_o};

  typedef struct { bit is_d; bit we; logic [31:0] data; } exp_t;
  typedef struct {
    bit if_v; bit d_v; bit we;
    logic [31:0] if_addr; logic [31:0] d_addr; logic [31:0] wdata;
    int lat; int fl_lo; int fl_hi; bit exp_d; bit exp_pulse;
  } txn_t;
  typedef struct { bit if_v; bit d_v; bit exp_d; } arb_t;

  exp_t        sb_q[$];
  int          errors = 0;
  int          checks = 0;
  bit          no_push = 1'b0;
  int          mem_lat = 1;
  int          pend = 0;
  logic [31:0] pend_data = '0;
  logic [31:0] mem_a [logic [31:0]];

  function automatic logic [31:0] mem_read(input logic [31:0] a);
    if (mem_a.exists(a)) return mem_a[a];
    return 32'h5A5A_0000 ^ (a * 32'd3);
  endfunction

  task automatic check(input string name, input logic [159:0] act, input logic [159:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  task automatic sample();
    @(negedge clk_i);
  endtask

  task automatic rsp_check(input bit is_d, input logic [31:0] data);
    exp_t e;
    checks++;
    if (sb_q.size() == 0) begin
      errors++;
      $display("FAIL rsp_unexpected: %s pulse with data 0x%08h, expected no pulse", is_d ? "d" : "if", data);
      return;
    end
    e = sb_q.pop_front();
    if (e.is_d != is_d) begin
      errors++;
      $display("FAIL rsp_owner: got %s pulse expected %s pulse", is_d ? "d" : "if", e.is_d ? "d" : "if");
    end else if (!e.we && data !== e.data) begin
      errors++;
      $display("FAIL rsp_data: got 0x%08h expected 0x%08h", data, e.data);
    end
  endtask

  // Memory model: answers mem_lat cycles after the strobe
  initial forever begin
    @(negedge clk_i);
    mem_rsp_valid_i = 1'b0;
    if (pend > 0) begin
      pend--;
      if (pend == 0) begin
        mem_rsp_valid_i = 1'b1;
        mem_rsp_data_i  = pend_data;
      end
    end
    if (mem_req_valid_o) begin
      if (mem_req_we_o) begin
        mem_a[mem_req_addr_o] = mem_req_wdata_o;
        pend_data = 32'h0BAD_57E0;
      end else begin
        pend_data = mem_read(mem_req_addr_o);
      end
      pend = mem_lat;
    end
  end

  // Scoreboard: push on accept, pop on response pulse
  initial forever begin
    @(negedge clk_i);
    if (if_req_ready_o && !no_push) sb_q.push_back('{1'b0, 1'b0, mem_read(if_req_addr_i)});
    if (d_req_ready_o && !no_push)
      sb_q.push_back('{1'b1, d_req_we_i, d_req_we_i ? 32'h0 : mem_read(d_req_addr_i)});
    if (if_rsp_valid_o) rsp_check(1'b0, if_rsp_data_o);
    if (d_rsp_valid_o)  rsp_check(1'b1, d_rsp_data_o);
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation still running at %0t, expected completion", $time);
    $fatal(1, "watchdog");
  end

  task automatic wait_idle();
    for (int w = 0; w < 50; w++) begin
      sample();
      if (!busy_o) return;
    end
    checks++;
    errors++;
    $display("FAIL wait_idle: busy_o still 1 after 50 cycles, expected 0");
  endtask

  task automatic run_txn(input int idx, input txn_t t);
    int   last;
    bit   bad;
    logic pulse;
    wait_idle();
    mem_lat = t.lat;
    no_push = !t.exp_pulse;
    last    = t.lat + 3;
    bad     = 1'b0;
    for (int c = 0; c <= last; c++) begin
      step();
      flush_i = (c >= t.fl_lo) && (c <= t.fl_hi);
      if (c == 0) begin
        if_req_valid_i = t.if_v;  if_req_addr_i = t.if_addr;
        d_req_valid_i  = t.d_v;   d_req_we_i = t.we;
        d_req_addr_i   = t.d_addr; d_req_wdata_i = t.wdata;
      end else if (c == 1) begin
        if_req_valid_i = 1'b0;
        d_req_valid_i  = 1'b0;
      end
      sample();
      pulse = t.exp_d ? d_rsp_valid_o : if_rsp_valid_o;
      if (c == 0)
        check($sformatf("t%0d_ready", idx), 160'({if_req_ready_o, d_req_ready_o}), 160'({~t.exp_d, t.exp_d}));
      if (c == 1) begin
        check($sformatf("t%0d_mem_req", idx), 160'({mem_req_valid_o, mem_req_we_o, mem_req_addr_o}),
              160'({1'b1, t.exp_d & t.we, t.exp_d ? t.d_addr : t.if_addr}));
        if (t.exp_d && t.we) check($sformatf("t%0d_wdata", idx), 160'(mem_req_wdata_o), 160'(t.wdata));
      end
      if (c == last - 1)
        check($sformatf("t%0d_pulse_busy", idx), 160'({pulse, busy_o}), 160'({t.exp_pulse, 1'b1}));
      else if (pulse) bad = 1'b1;
      if (c == last) check($sformatf("t%0d_idle", idx), 160'(busy_o), 160'(1'b0));
    end
    check($sformatf("t%0d_no_stray_pulse", idx), 160'(bad), 160'(1'b0));
    flush_i = 1'b0;
    no_push = 1'b0;
  endtask

  txn_t tv [11];
  arb_t av [18];

  initial begin
    bit got;
    bit bad;
    mem_a[32'h40] = 32'hDEADBEEF;
    //          if d  we if_addr      d_addr       wdata         lat lo  hi  exp_d pulse
    tv[0]  = '{1, 0, 0, 32'h40,  32'h0,   32'h0,         1, 99, 0, 0, 1};
    tv[1]  = '{0, 1, 0, 32'h0,   32'h10,  32'h0,         2, 99, 0, 1, 1};
    tv[2]  = '{0, 1, 1, 32'h0,   32'h300, 32'hCAFEF00D,  4, 99, 0, 1, 1};
    tv[3]  = '{0, 1, 0, 32'h0,   32'h300, 32'h0,         1, 99, 0, 1, 1};
    tv[4]  = '{1, 0, 0, 32'h80,  32'h0,   32'h0,         5, 3,  3, 0, 0};
    tv[5]  = '{1, 0, 0, 32'h200, 32'h0,   32'h0,         1, 99, 0, 0, 1};
    tv[6]  = '{1, 0, 0, 32'h44,  32'h0,   32'h0,         1, 3,  3, 0, 0};
    tv[7]  = '{0, 1, 0, 32'h0,   32'h10,  32'h0,         2, 1,  4, 1, 1};
    tv[8]  = '{1, 0, 0, 32'h48,  32'h0,   32'h0,         2, 0,  0, 0, 1};
    tv[9]  = '{1, 0, 0, 32'h4C,  32'h0,   32'h0,         3, 1,  1, 0, 0};
    tv[10] = '{0, 1, 1, 32'h0,   32'h304, 32'h0BADF00D,  1, 99, 0, 1, 1};
    for (int k = 0; k < 10; k++) av[k] = '{1, 1, (k != 4 && k != 9)};
    av[10] = '{0, 1, 1};
    av[11] = '{0, 1, 1};
    for (int k = 12; k < 17; k++) av[k] = '{1, 1, (k != 16)};
    av[17] = '{1, 0, 0};

    // Reset state
    for (int c = 0; c < 3; c++) begin
      step();
      sample();
      if (c > 0) check($sformatf("reset_outs_%0d", c), 160'(all_outs), 160'(0));
    end
    step();
    rst_i = 1'b1;
    if_req_valid_i = 1'b1;
    if_req_addr_i  = 32'h40;
    sample();
    check("post_reset_outs", 160'(all_outs), 160'(0));
    step();
    if_req_valid_i = 1'b0;
    if_req_addr_i  = 32'h0;

    for (int k = 0; k < 11; k++) run_txn(k, tv[k]);

    // Store and fetch together: data first, fetch in the next IDLE cycle
    wait_idle();
    mem_lat = 3;
    step();
    if_req_valid_i = 1'b1; if_req_addr_i = 32'h60;
    d_req_valid_i = 1'b1; d_req_we_i = 1'b1; d_req_addr_i = 32'h100; d_req_wdata_i = 32'h12345678;
    sample();
    check("sf_ready", 160'({if_req_ready_o, d_req_ready_o}), 160'(2'b01));
    step();
    d_req_valid_i = 1'b0;
    sample();
    check("sf_mem_req", 160'({mem_req_valid_o, mem_req_we_o, mem_req_addr_o, mem_req_wdata_o}),
          160'({1'b1, 1'b1, 32'h100, 32'h12345678}));
    bad = 1'b0;
    for (int c = 2; c <= 6; c++) begin
      step();
      sample();
      if (c == 5) check("sf_store_ack", 160'(d_rsp_valid_o), 160'(1'b1));
      else if (d_rsp_valid_o || if_req_ready_o && c < 6) bad = 1'b1;
      if (c == 6) check("sf_fetch_ready", 160'({if_req_ready_o, d_req_ready_o}), 160'(2'b10));
    end
    check("sf_no_stray", 160'(bad), 160'(1'b0));
    step();
    if_req_valid_i = 1'b0;
    wait_idle();

    // Starvation guard: grant order with both requesters held valid
    mem_lat = 1;
    if_req_addr_i = 32'h1000;
    d_req_addr_i  = 32'h2000;
    d_req_we_i    = 1'b0;
    for (int k = 0; k < 18; k++) begin
      step();
      if_req_valid_i = av[k].if_v;
      d_req_valid_i  = av[k].d_v;
      got = 1'b0;
      for (int w = 0; w < 40 && !got; w++) begin
        sample();
        if (if_req_ready_o || d_req_ready_o) got = 1'b1;
        else step();
      end
      if (!got) begin
        checks++;
        errors++;
        $display("FAIL arb%0d_timeout: no ready within 40 cycles, expected a grant", k);
      end else begin
        check($sformatf("arb%0d_grant", k), 160'({if_req_ready_o, d_req_ready_o}),
              160'({~av[k].exp_d, av[k].exp_d}));
      end
    end
    step();
    if_req_valid_i = 1'b0;
    d_req_valid_i  = 1'b0;
    wait_idle();

    // Reset during WAIT of a load; late memory response must be ignored
    mem_lat = 4;
    no_push = 1'b1;
    step();
    d_req_valid_i = 1'b1; d_req_we_i = 1'b0; d_req_addr_i = 32'h10;
    sample();
    check("rst_load_ready", 160'(d_req_ready_o), 160'(1'b1));
    step();
    d_req_valid_i = 1'b0;
    sample();
    step();
    rst_i = 1'b0;
    sample();
    check("rst_outs_c2", 160'(all_outs), 160'(0));
    step();
    sample();
    check("rst_outs_c3", 160'(all_outs), 160'(0));
    step();
    rst_i = 1'b1;
    no_push = 1'b0;
    mem_lat = 1;
    d_req_valid_i = 1'b1; d_req_addr_i = 32'h20;
    sample();
    check("rst_outs_after", 160'(all_outs), 160'(0));
    step();
    sample();
    check("rst_next_ready", 160'(d_req_ready_o), 160'(1'b1));
    step();
    d_req_valid_i = 1'b0;
    sample();
    check("rst_next_mem_req", 160'({mem_req_valid_o, mem_req_addr_o}), 160'({1'b1, 32'h20}));
    bad = 1'b0;
    for (int c = 7; c <= 8; c++) begin
      step();
      sample();
      if (c == 8) check("rst_next_rsp", 160'(d_rsp_valid_o), 160'(1'b1));
      else if (d_rsp_valid_o) bad = 1'b1;
    end
    check("rst_no_stale_rsp", 160'(bad), 160'(1'b0));
    wait_idle();

    check("scoreboard_empty", 160'(sb_q.size()), 160'(0));
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
